// File: rtl/skip_count_pkg.sv
// Shared types and arithmetic for the skip-multiple counter: the sequencer state
// type and the successor, maximum and start-normalisation helpers.
package skip_count_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Largest WIDTH-bit value that is not a nonzero multiple of modv.
  function automatic int skip_max(input int width, input int modv);
    int top;
    top = (1 << width) - 1;
    if (top % modv == 0) top = top - 1;
    return top;
  endfunction

  function automatic int skip_next(input int v, input int modv, input int maxv);
    int n;
    if (v == maxv) n = 0;
    else if ((v + 1) % modv == 0) n = v + 2;
    else n = v + 1;
    return n;
  endfunction

  function automatic int skip_norm(input int start, input int modv, input int maxv);
    int n;
    if (start > maxv) n = 0;
    else if (start != 0 && start % modv == 0) n = start + 1;
    else n = start;
    return n;
  endfunction

endpackage

// File: rtl/skip_counter.sv
// Count register stepping through the skip-multiple sequence.
// Load takes priority over enable.
module skip_counter
  import skip_count_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MOD   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] value
);

  localparam int MAXV = skip_max(WIDTH, MOD);

  logic [WIDTH-1:0] next_val;

  always_comb next_val = WIDTH'(skip_next(int'(value), MOD, MAXV));

  always_ff @(posedge clk) begin
    if (rst) value <= '0;
    else if (load) value <= load_val;
    else if (en) value <= next_val;
  end

endmodule

// File: rtl/skip_count_seq.sv
// Command-driven sequencer: accepts (start, length), streams that many skip-sequence
// values on a valid/ready port, then pulses done. Length 0 runs until abort.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | streaming values, out_valid high
// DONE  | one-cycle completion pulse after the last finite beat
module skip_count_seq
  import skip_count_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MOD   = 3,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             start_adj,
  output logic             busy,
  output logic             done
);

  localparam int MAXV = skip_max(WIDTH, MOD);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining;
  logic             cont;
  logic             accept;
  logic             beat;
  logic [WIDTH-1:0] first_val;

  assign first_val = WIDTH'(skip_norm(int'(cmd_start), MOD, MAXV));

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    accept    = 1'b0;
    beat      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        accept    = cmd_valid;
        if (cmd_valid) state_nxt = RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        out_last  = !cont && (remaining == LEN_W'(1));
        beat      = out_ready;
        // abort wins over a same-cycle handshake; the beat is simply dropped
        if (abort) state_nxt = IDLE;
        else if (out_ready && out_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      cont      <= 1'b0;
      start_adj <= 1'b0;
    end else begin
      state     <= state_nxt;
      start_adj <= accept && (first_val != cmd_start);
      if (accept) begin
        remaining <= cmd_len;
        cont      <= (cmd_len == '0);
      end else if (beat && !cont) begin
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  skip_counter #(
    .WIDTH(WIDTH),
    .MOD  (MOD)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .load_val(first_val),
    .en      (beat),
    .value   (out_data)
  );

  assert property (@(posedge clk) disable iff (rst)
    out_valid |-> (out_data == '0 || (int'(out_data) % MOD) != 0));

endmodule

// File: tb/tb_skip_count_seq.sv
// Directed bench for skip_count_seq: a table of finite commands plus hand-written
// stall, continuous/abort and mid-run reset sequences.
module tb_skip_count_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_start;
  logic [15:0] cmd_len;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        start_adj;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]      start;
    logic [15:0]     len;
    logic            adj;
    logic [0:7][7:0] exp;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  skip_count_seq #(.WIDTH(8), .MOD(3), .LEN_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_start(cmd_start),
    .cmd_len  (cmd_len),
    .abort    (abort),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .start_adj(start_adj),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_next(input logic [7:0] v);
    logic [8:0] n;
    if (v == 8'd254) return 8'd0;
    n = {1'b0, v} + 9'd1;
    if (n % 3 == 0) n = n + 9'd1;
    return n[7:0];
  endfunction

  task automatic issue(input logic [7:0] s, input logic [15:0] l);
    cmd_valid = 1'b1;
    cmd_start = s;
    cmd_len   = l;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    chk("idle_cmd_ready", cmd_ready, 1);
    out_ready = 1'b1;
    issue(v.start, v.len);
    chk("start_adj", start_adj, v.adj);
    for (int i = 0; i < int'(v.len); i++) begin
      chk("beat_valid", out_valid, 1);
      chk("beat_data", out_data, v.exp[i]);
      chk("beat_last", out_last, (i == int'(v.len) - 1));
      chk("run_cmd_ready", cmd_ready, 0);
      @(negedge clk);
    end
    chk("done_pulse", done, 1);
    chk("done_valid", out_valid, 0);
    chk("done_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    chk("after_done", done, 0);
    chk("after_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    logic [7:0] exp_seq [8];
    logic [7:0] prev_data;
    logic [7:0] model;
    logic       prev_stall;
    int         idx, bad, wraps, lasts, dones;

    vecs[0] = '{start: 8'd0,   len: 16'd6, adj: 1'b0,
                exp: {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd7, 8'd0, 8'd0}};
    vecs[1] = '{start: 8'd253, len: 16'd4, adj: 1'b0,
                exp: {8'd253, 8'd254, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[2] = '{start: 8'd9,   len: 16'd2, adj: 1'b1,
                exp: {8'd10, 8'd11, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[3] = '{start: 8'd255, len: 16'd1, adj: 1'b1,
                exp: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[4] = '{start: 8'd254, len: 16'd3, adj: 1'b0,
                exp: {8'd254, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[5] = '{start: 8'd6,   len: 16'd3, adj: 1'b1,
                exp: {8'd7, 8'd8, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
    exp_seq = '{8'd1, 8'd2, 8'd4, 8'd5, 8'd7, 8'd8, 8'd10, 8'd11};

    rst = 1'b1; cmd_valid = 1'b0; cmd_start = '0; cmd_len = '0;
    abort = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_start_adj", start_adj, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[k]) run_vec(vecs[k]);

    // Random stalls: sequence must be exact and data stable while stalled.
    out_ready = 1'b0;
    issue(8'd1, 16'd8);
    chk("stall_adj", start_adj, 0);
    idx = 0; prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 200 && idx < 8; cyc++) begin
      if (cyc != 0) @(negedge clk);
      chk("stall_valid", out_valid, 1);
      if (prev_stall) chk("stall_stable", out_data, prev_data);
      out_ready = 1'($urandom_range(0, 1));
      if (out_ready) begin
        chk("stall_data", out_data, exp_seq[idx]);
        chk("stall_last", out_last, (idx == 7));
        idx++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        prev_data  = out_data;
      end
    end
    chk("stall_all_beats", idx, 8);
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("stall_one_done", dones, 1);
    chk("stall_idle", cmd_ready, 1);

    // Continuous mode: 400 beats wrap twice, then abort.
    out_ready = 1'b1;
    issue(8'd0, 16'd0);
    model = 8'd0; bad = 0; wraps = 0; lasts = 0;
    for (int b = 0; b < 400; b++) begin
      if (b != 0) @(negedge clk);
      if (!out_valid || out_data != model) bad++;
      if (out_last) lasts++;
      if (b == 399) cmd_valid = 1'b1;  // must be ignored while running
      if (model == 8'd254) wraps++;
      model = model_next(model);
    end
    chk("cont_data_bad", bad, 0);
    chk("cont_wraps", wraps, 2);
    chk("cont_no_last", lasts, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cont_ignores_cmd", out_data, model);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_no_done", done, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    chk("abort_still_no_done", done, 0);

    // Reset mid-run while holding value 100.
    out_ready = 1'b0;
    issue(8'd100, 16'd0);
    chk("pre_rst_data", out_data, 100);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    run_vec('{start: 8'd2, len: 16'd2, adj: 1'b0,
              exp: {8'd2, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual running required finished");
    $fatal(1);
  end

endmodule
